i2s_tx_arb: RTL and testbench
=============================

I2S_TX_ARB -- requirements
Module: i2s_tx_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the bits per audio sample word.
REQ-002 The block SHALL have parameter PORTS, default 4, giving the number of requesting stereo sources (2..16).
REQ-003 The block SHALL have parameter BURST, default 4, giving the maximum stereo frames per grant (>=1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port enable, input, 1 bit: when high, new grants are permitted.
REQ-007 The block SHALL have port s_axis_l_tdata, input, PORTS*WIDTH bits: per-port left sample; port i occupies bits [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port s_axis_r_tdata, input, PORTS*WIDTH bits: per-port right sample, packed the same way.
REQ-009 The block SHALL have port s_axis_tvalid, input, PORTS bits: per-port frame valid.
REQ-010 The block SHALL have port s_axis_tready, output, PORTS bits: per-port frame accept.
REQ-011 The block SHALL have port m_axis_l_tdata, output, WIDTH bits: left sample to the I2S transmitter.
REQ-012 The block SHALL have port m_axis_r_tdata, output, WIDTH bits: right sample to the I2S transmitter.
REQ-013 The block SHALL have port m_axis_tvalid, output, 1 bit: output frame valid.
REQ-014 The block SHALL have port m_axis_tready, input, 1 bit: the transmitter accepts the frame.
REQ-015 The block SHALL have port grant, output, PORTS bits: one-hot current grant, all zero when idle.
REQ-016 The block SHALL have port grant_valid, output, 1 bit: high while in ACTIVE.

Function
REQ-017 The block SHALL implement two states, IDLE and ACTIVE, with a round-robin pointer rr_ptr (0..PORTS-1) and a frame counter cnt (0..BURST-1).
REQ-018 In IDLE, when enable=1 and any s_axis_tvalid bit is set, the block SHALL select the first valid port at or after rr_ptr in circular order, register grant to that port, clear cnt and enter ACTIVE on the next clock.
REQ-019 In IDLE, and in ACTIVE on non-granted ports, s_axis_tready SHALL be 0.
REQ-020 In ACTIVE, s_axis_tready[g] SHALL equal (~m_axis_tvalid | m_axis_tready), where g is the granted port.
REQ-021 A transfer on port g (tvalid & tready) SHALL load both of that port's samples into the output registers and set m_axis_tvalid on the next clock, giving 1-cycle latency; left/right pairs are never split.
REQ-022 m_axis_tvalid SHALL clear when m_axis_tready=1 and no new transfer occurs in the same cycle.
REQ-023 Output data SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-024 In ACTIVE, each transfer SHALL increment cnt; a transfer with cnt=BURST-1 SHALL release the grant.
REQ-025 In ACTIVE, a cycle in which s_axis_tvalid[g]=0 SHALL release the grant; a stalled output (tvalid[g]=1, tready[g]=0) SHALL NOT release it.
REQ-026 On release, the block SHALL set rr_ptr=(g+1) mod PORTS, clear grant and enter IDLE; re-arbitration occurs in the following cycle, giving one bubble cycle between grants.
REQ-027 Deasserting enable SHALL NOT truncate the current grant; it only blocks new grants from IDLE.
REQ-028 Release and the final transfer in the same cycle SHALL both take effect: the frame is accepted and the state enters IDLE.

Reset
REQ-029 While rst=1 at a clock edge, the block SHALL enter IDLE with rr_ptr=0, cnt=0, grant=0, grant_valid=0, s_axis_tready=0, m_axis_tvalid=0 and m_axis_l/r_tdata=0.
REQ-030 Reset asserted mid-burst SHALL discard any pending output frame, with no transfer completing in the reset cycle.

Verification
REQ-031 The bench SHALL cover: all ports valid, m_axis_tready=1, BURST=4 -> grants 0,1,2,3,0 in order, 4 frames each, one bubble between grants.
REQ-032 The bench SHALL cover: only port 2 valid with rr_ptr=3 -> port 2 is granted 1 cycle after tvalid rises; the output appears 1 cycle after the transfer.
REQ-033 The bench SHALL cover: port 1 granted, tvalid drops after 2 frames -> release after 2 frames; rr_ptr=2.
REQ-034 The bench SHALL cover: m_axis_tready=0 for 5 cycles with a frame pending -> output data/valid stable, tready[g]=0, grant held; then resumes with no frame loss or duplication.
REQ-035 The bench SHALL cover: enable=0 mid-burst -> the burst completes to BURST frames, then IDLE with no further grant until enable=1.
REQ-036 The bench SHALL cover: rst pulsed during ACTIVE with m_axis_tvalid=1 -> next cycle all outputs 0 and rr_ptr=0.

Source files
------------

// File: rtl/i2s_tx_arb.sv
// i2s_tx_arb: round-robin arbiter that feeds stereo frames from PORTS sources into one
// I2S transmitter stream. A grant lasts up to BURST frames, or until the granted source
// runs dry. Each release is followed by one idle (bubble) cycle before re-arbitration.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   enable              permits new grants from IDLE; never truncates a running grant
//   s_axis_l/r_tdata    per-source left/right samples, source i at [i*WIDTH +: WIDTH]
//   s_axis_tvalid/ready per-source frame handshake
//   m_axis_l/r_tdata    registered output frame
//   m_axis_tvalid/ready output frame handshake
//   grant, grant_valid  one-hot current owner (zero when idle), high while ACTIVE
module i2s_tx_arb #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned PORTS = 4,
    parameter int unsigned BURST = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [PORTS*WIDTH-1:0] s_axis_l_tdata,
    input  logic [PORTS*WIDTH-1:0] s_axis_r_tdata,
    input  logic [PORTS-1:0]       s_axis_tvalid,
    output logic [PORTS-1:0]       s_axis_tready,
    output logic [WIDTH-1:0]       m_axis_l_tdata,
    output logic [WIDTH-1:0]       m_axis_r_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [PORTS-1:0]       grant,
    output logic                   grant_valid
);

    localparam int unsigned PW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int unsigned CW = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic {StIdle, StActive} state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]    gidx_q, gidx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PORTS-1:0] grant_q, grant_d;
    logic [WIDTH-1:0] l_q, l_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             mvalid_q, mvalid_d;

    logic             active;
    logic             out_free;
    logic             gvalid;
    logic             xfer;
    logic             last;
    logic             release_now;
    logic [PW-1:0]    pick_idx;
    logic             pick_found;
    int unsigned      cand;

    // First valid source at or after rr_ptr, searched circularly.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int unsigned k = 0; k < PORTS; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= PORTS) begin
                cand = cand - PORTS;
            end
            if (!pick_found && s_axis_tvalid[PW'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = PW'(cand);
            end
        end
    end

    assign active   = (state_q == StActive);
    assign out_free = ~mvalid_q | m_axis_tready;
    assign gvalid   = s_axis_tvalid[gidx_q];
    // Reset gating keeps any handshake from completing in a reset cycle.
    assign xfer     = active & gvalid & out_free & ~rst;
    assign last     = (cnt_q == CW'(BURST - 1));
    // A dry source ends the grant; a stalled output (valid but not ready) does not.
    assign release_now = active & (~gvalid | (xfer & last));

    assign s_axis_tready  = (active && out_free && !rst) ? grant_q : '0;
    assign m_axis_tvalid  = mvalid_q & ~rst;
    assign m_axis_l_tdata = l_q;
    assign m_axis_r_tdata = r_q;
    assign grant          = grant_q;
    assign grant_valid    = active;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gidx_d   = gidx_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        l_d      = l_q;
        r_d      = r_q;
        mvalid_d = mvalid_q;

        // Output register: load a whole L/R pair, or drain when the transmitter takes it.
        if (xfer) begin
            l_d      = s_axis_l_tdata[32'(gidx_q) * WIDTH +: WIDTH];
            r_d      = s_axis_r_tdata[32'(gidx_q) * WIDTH +: WIDTH];
            mvalid_d = 1'b1;
        end else if (m_axis_tready) begin
            mvalid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (enable && pick_found) begin
                    state_d           = StActive;
                    gidx_d            = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    cnt_d             = '0;
                end
            end
            StActive: begin
                if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (release_now) begin
                    state_d  = StIdle;
                    grant_d  = '0;
                    cnt_d    = '0;
                    rr_ptr_d = (gidx_q == PW'(PORTS - 1)) ? '0 : gidx_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            gidx_q   <= '0;
            cnt_q    <= '0;
            grant_q  <= '0;
            l_q      <= '0;
            r_q      <= '0;
            mvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gidx_q   <= gidx_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            l_q      <= l_d;
            r_q      <= r_d;
            mvalid_q <= mvalid_d;
        end
    end

endmodule

// File: tb/tb_i2s_tx_arb.sv
// Bench for i2s_tx_arb: hand-derived vector table, directed multi-cycle sequences and a
// randomized run, all checked against a frame-level reference model and a scoreboard.
module tb_i2s_tx_arb;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned PORTS = 4;
    localparam int unsigned BURST = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   enable;
    logic [PORTS*WIDTH-1:0] s_l;
    logic [PORTS*WIDTH-1:0] s_r;
    logic [PORTS-1:0]       s_tvalid;
    logic [PORTS-1:0]       s_tready;
    logic [WIDTH-1:0]       m_l;
    logic [WIDTH-1:0]       m_r;
    logic                   m_tvalid;
    logic                   m_tready;
    logic [PORTS-1:0]       grant;
    logic                   grant_valid;

    i2s_tx_arb #(
        .WIDTH(WIDTH),
        .PORTS(PORTS),
        .BURST(BURST)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .s_axis_l_tdata(s_l),
        .s_axis_r_tdata(s_r),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_l_tdata(m_l),
        .m_axis_r_tdata(m_r),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .grant         (grant),
        .grant_valid   (grant_valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the stream, how many frames it has sent, where the
    // round-robin search starts next, and what the output register holds.
    bit               mb_busy;
    int               mb_owner;
    int               mb_cnt;
    int               mb_ptr;
    bit               mb_ov;
    logic [WIDTH-1:0] mb_ol;
    logic [WIDTH-1:0] mb_or;

    logic [2*WIDTH-1:0] sb[$];

    logic [PORTS-1:0] obs_grant;
    logic [PORTS-1:0] obs_tready;
    logic             obs_gv;
    logic             obs_mv;
    logic [WIDTH-1:0] obs_ml;
    logic [WIDTH-1:0] obs_mr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        logic [PORTS-1:0] e_g;
        logic [PORTS-1:0] e_tr;
        e_g  = '0;
        e_tr = '0;
        if (mb_busy) begin
            e_g[mb_owner] = 1'b1;
            if (!rst && (!mb_ov || m_tready)) e_tr[mb_owner] = 1'b1;
        end
        chk("grant", 64'(grant), 64'(e_g));
        chk("grant_valid", 64'(grant_valid), 64'(mb_busy));
        chk("s_tready", 64'(s_tready), 64'(e_tr));
        chk("m_tvalid", 64'(m_tvalid), 64'(mb_ov && !rst));
        chk("m_l_tdata", 64'(m_l), 64'(mb_ol));
        chk("m_r_tdata", 64'(m_r), 64'(mb_or));
    endtask

    task automatic model_update();
        bit xf;
        bit found;
        int p;
        if (rst) begin
            mb_busy = 0; mb_owner = 0; mb_cnt = 0; mb_ptr = 0;
            mb_ov = 0; mb_ol = '0; mb_or = '0;
            sb.delete();
        end else begin
            xf = mb_busy && s_tvalid[mb_owner] && (!mb_ov || m_tready);
            if (xf) begin
                mb_ov = 1;
                mb_ol = s_l[mb_owner*WIDTH +: WIDTH];
                mb_or = s_r[mb_owner*WIDTH +: WIDTH];
            end else if (m_tready) begin
                mb_ov = 0;
            end
            if (mb_busy) begin
                if (xf) mb_cnt++;
                if (!s_tvalid[mb_owner] || (xf && mb_cnt == BURST)) begin
                    mb_busy = 0;
                    mb_ptr  = (mb_owner + 1) % PORTS;
                end
            end else if (enable && s_tvalid != '0) begin
                found = 0;
                for (int k = 0; k < PORTS; k++) begin
                    p = (mb_ptr + k) % PORTS;
                    if (!found && s_tvalid[p]) begin
                        found    = 1;
                        mb_owner = p;
                    end
                end
                mb_busy = 1;
                mb_cnt  = 0;
            end
        end
    endtask

    // Every frame accepted from a source must leave the output exactly once, in order.
    task automatic sb_step();
        if (!rst) begin
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_frame: got %0h expected no frame at %0t", {m_l, m_r}, $time);
                end else begin
                    chk("sb_frame", 64'({m_l, m_r}), 64'(sb.pop_front()));
                end
            end
            for (int i = 0; i < PORTS; i++) begin
                if (s_tvalid[i] && s_tready[i]) sb.push_back({s_l[i*WIDTH +: WIDTH], s_r[i*WIDTH +: WIDTH]});
            end
        end
    endtask

    // Inputs are set at posedge+1; outputs are sampled mid-cycle; model advances at the edge.
    task automatic tick();
        for (int i = 0; i < PORTS; i++) begin
            s_l[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            s_r[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
        #4;
        obs_grant  = grant;
        obs_tready = s_tready;
        obs_gv     = grant_valid;
        obs_mv     = m_tvalid;
        obs_ml     = m_l;
        obs_mr     = m_r;
        model_check();
        sb_step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        bit         en;
        logic [3:0] tv;
        bit         mr;
        logic [3:0] g;
        logic [3:0] tr;
        bit         mv;
    } vec_t;

    vec_t tbl[18];

    initial begin
        logic [WIDTH-1:0] hold_l;
        logic [WIDTH-1:0] hold_r;
        logic [PORTS-1:0] exp_g;
        int               acc;

        rst = 1'b1; enable = 1'b0; s_tvalid = '0; m_tready = 1'b1; s_l = '0; s_r = '0;
        mb_busy = 0; mb_owner = 0; mb_cnt = 0; mb_ptr = 0; mb_ov = 0; mb_ol = '0; mb_or = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Port 2 alone, then port 2 again with rr_ptr=3, then port 1 for two frames.
        tbl[0]  = '{1, 4'b0000, 1, 4'b0000, 4'b0000, 0};
        tbl[1]  = '{1, 4'b0100, 1, 4'b0000, 4'b0000, 0};
        tbl[2]  = '{1, 4'b0100, 1, 4'b0100, 4'b0100, 0};
        tbl[3]  = '{1, 4'b0100, 1, 4'b0100, 4'b0100, 1};
        tbl[4]  = '{1, 4'b0000, 1, 4'b0100, 4'b0100, 1};
        tbl[5]  = '{1, 4'b0000, 1, 4'b0000, 4'b0000, 0};
        tbl[6]  = '{1, 4'b0100, 1, 4'b0000, 4'b0000, 0};
        tbl[7]  = '{1, 4'b0100, 1, 4'b0100, 4'b0100, 0};
        tbl[8]  = '{1, 4'b0000, 1, 4'b0100, 4'b0100, 1};
        tbl[9]  = '{1, 4'b0010, 1, 4'b0000, 4'b0000, 0};
        tbl[10] = '{1, 4'b0010, 1, 4'b0010, 4'b0010, 0};
        tbl[11] = '{1, 4'b0010, 1, 4'b0010, 4'b0010, 1};
        tbl[12] = '{1, 4'b0000, 1, 4'b0010, 4'b0010, 1};
        tbl[13] = '{0, 4'b1111, 1, 4'b0000, 4'b0000, 0};
        tbl[14] = '{1, 4'b1111, 1, 4'b0000, 4'b0000, 0};
        tbl[15] = '{1, 4'b1111, 1, 4'b0100, 4'b0100, 0};
        tbl[16] = '{1, 4'b0000, 1, 4'b0100, 4'b0100, 1};
        tbl[17] = '{1, 4'b0000, 1, 4'b0000, 4'b0000, 0};

        for (int i = 0; i < 18; i++) begin
            enable   = tbl[i].en;
            s_tvalid = tbl[i].tv;
            m_tready = tbl[i].mr;
            tick();
            chk($sformatf("tbl%0d_grant", i), 64'(obs_grant), 64'(tbl[i].g));
            chk($sformatf("tbl%0d_tready", i), 64'(obs_tready), 64'(tbl[i].tr));
            chk($sformatf("tbl%0d_mvalid", i), 64'(obs_mv), 64'(tbl[i].mv));
        end

        // All sources valid: 0,1,2,3,0, four frames each, one bubble between grants.
        do_reset();
        enable = 1'b1; s_tvalid = '1; m_tready = 1'b1;
        for (int c = 0; c < 26; c++) begin
            tick();
            exp_g = '0;
            if (c % 5 != 0) exp_g[(c / 5) % 4] = 1'b1;
            chk($sformatf("rr_c%0d_grant", c), 64'(obs_grant), 64'(exp_g));
        end

        // Output stall for 5 cycles with a frame pending.
        do_reset();
        enable = 1'b1; s_tvalid = '1; m_tready = 1'b1;
        tick();
        tick();
        hold_l = mb_ol;
        hold_r = mb_or;
        m_tready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("stall_mvalid", 64'(obs_mv), 64'(1));
            chk("stall_l", 64'(obs_ml), 64'(hold_l));
            chk("stall_r", 64'(obs_mr), 64'(hold_r));
            chk("stall_tready", 64'(obs_tready), 64'(0));
            chk("stall_grant", 64'(obs_grant), 64'(4'b0001));
        end
        m_tready = 1'b1;
        repeat (12) tick();

        // enable dropped mid-burst: burst completes, then no new grant until enable returns.
        do_reset();
        enable = 1'b1; s_tvalid = '1; m_tready = 1'b1;
        acc = 0;
        tick();
        tick();
        if (obs_tready[0]) acc++;
        enable = 1'b0;
        repeat (3) begin
            tick();
            if (obs_tready[0]) acc++;
        end
        chk("en_off_burst_frames", 64'(acc), 64'(BURST));
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("en_off_idle_grant", 64'(obs_grant), 64'(0));
        end
        enable = 1'b1;
        tick();
        tick();
        chk("en_on_grant", 64'(obs_grant), 64'(4'b0010));

        // Reset during ACTIVE with a pending output frame.
        do_reset();
        enable = 1'b1; s_tvalid = '1; m_tready = 1'b1;
        repeat (7) tick();
        chk("pre_rst_grant", 64'(grant), 64'(4'b0010));
        rst = 1'b1;
        tick();
        chk("rst_cycle_tready", 64'(obs_tready), 64'(0));
        rst = 1'b0;
        tick();
        chk("post_rst_grant", 64'(obs_grant), 64'(0));
        chk("post_rst_gv", 64'(obs_gv), 64'(0));
        chk("post_rst_mvalid", 64'(obs_mv), 64'(0));
        chk("post_rst_data", 64'({obs_ml, obs_mr}), 64'(0));
        tick();
        chk("post_rst_ptr0", 64'(obs_grant), 64'(4'b0001));

        // Randomized traffic against the model and scoreboard.
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 299) == 0);
            enable   = ($urandom_range(0, 9) != 0);
            m_tready = ($urandom_range(0, 9) < 6);
            for (int i = 0; i < PORTS; i++) s_tvalid[i] = ($urandom_range(0, 9) < 7);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
